// File: rtl/vga_pattern_sequencer_pkg.sv
// vga_pkg: FSM state encoding, V_ACTIVE default and pattern index width for the sequencer
package vga_pkg;
  localparam logic [0:0] MANUAL = 1'b0;
  localparam logic [0:0] AUTO = 1'b1;
  localparam int V_ACTIVE_DEF = 1024;
  localparam int PATTERN_W = 2;
endpackage

// File: rtl/vga_pattern_sequencer_if.sv
// vga_pattern_sequencer_if: timing counters, raw buttons and pattern-select outputs
//   master drives hc/vc/btn_next/btn_mode and observes the outputs
//   slave (the sequencer) receives the inputs and drives pattern_sel/auto_mode/pattern_update
interface vga_pattern_sequencer_if;
  logic [10:0] hc;
  logic [10:0] vc;
  logic btn_next;
  logic btn_mode;
  logic [vga_pkg::PATTERN_W-1:0] pattern_sel;
  logic auto_mode;
  logic pattern_update;
  modport master(output hc, vc, btn_next, btn_mode, input pattern_sel, auto_mode, pattern_update);
  modport slave(input hc, vc, btn_next, btn_mode, output pattern_sel, auto_mode, pattern_update);
endinterface

// File: rtl/vga_pattern_sequencer_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability debouncer and one-cycle rising-edge press pulse
//   clk, clr_n (async active-low), btn_i raw button, press_o one-cycle press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync_q;
  logic db_q, db_d, press_q, diff, done;
  logic [CW-1:0] cnt_q, cnt_d;
  // the counter only runs while the synchronized level disagrees; any agreement restarts it
  assign diff = sync_q[1] ^ db_q;
  assign done = diff && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  assign db_d = db_q ^ done;
  assign cnt_d = (diff && !done) ? cnt_q + 1'b1 : '0;
  assign press_o = press_q;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      sync_q <= '0;
      db_q <= 1'b0;
      cnt_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      db_q <= db_d;
      cnt_q <= cnt_d;
      press_q <= db_d & ~db_q;
    end
endmodule

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: button-driven MANUAL/AUTO pattern selector updating only at the frame boundary
//   clk pixel clock, clr_n async active-low reset
//   bus.hc/vc timing counters, bus.btn_next/btn_mode raw buttons
//   bus.pattern_sel, bus.auto_mode, bus.pattern_update registered outputs
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int NUM_PATTERNS = 4,
  parameter int AUTO_FRAMES = 60,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic clk,
  input logic clr_n,
  vga_pattern_sequencer_if.slave bus
);
  logic next_press, mode_press, frame_tick, expire, adv;
  logic [0:0] state_q, state_d;
  logic pend_q, pend_d, upd_q;
  logic [7:0] fcnt_q, fcnt_d;
  logic [PATTERN_W-1:0] sel_q, sel_d;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .clr_n(clr_n), .btn_i(bus.btn_next), .press_o(next_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .clr_n(clr_n), .btn_i(bus.btn_mode), .press_o(mode_press)
  );
  assign frame_tick = bus.hc == 11'd0 && bus.vc == 11'(V_ACTIVE);
  assign expire = state_q == AUTO && fcnt_q == 8'(AUTO_FRAMES - 1);
  // pending and auto-expiry merge into a single advance
  assign adv = frame_tick && (pend_q || expire);
  assign state_d = mode_press ? ~state_q : state_q;
  // a press coinciding with the tick is only registered, so it waits for the next tick
  assign pend_d = next_press || (pend_q && !frame_tick);
  assign fcnt_d = (mode_press || adv) ? 8'd0 : (frame_tick && state_q == AUTO) ? fcnt_q + 8'd1 : fcnt_q;
  assign sel_d = !adv ? sel_q : sel_q == PATTERN_W'(NUM_PATTERNS - 1) ? '0 : sel_q + 1'b1;
  assign bus.pattern_sel = sel_q;
  assign bus.auto_mode = state_q[0];
  assign bus.pattern_update = upd_q;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state_q <= MANUAL;
      pend_q <= 1'b0;
      fcnt_q <= '0;
      sel_q <= '0;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      fcnt_q <= fcnt_d;
      sel_q <= sel_d;
      upd_q <= adv;
    end
endmodule

// File: doc/vga_pattern_sequencer.md
VGA_PATTERN_SEQUENCER -- requirements
Module: vga_pattern_sequencer

Interface
REQ-001 Parameter V_ACTIVE, default 1024: vc value of the first vertical-blanking line, which marks the frame boundary.
REQ-002 Parameter NUM_PATTERNS, default 4, range 2..4: number of selectable patterns.
REQ-003 Parameter AUTO_FRAMES, default 60, range 1..255: frames per pattern in auto mode.
REQ-004 Parameter DEBOUNCE_CYCLES, default 1_000_000, minimum 2: clk cycles a button level must be stable to be accepted.
REQ-005 clk  in  1  pixel clock, the same clock that drives the timing generator.
REQ-006 clr_n  in  1  reset; the block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-007 hc  in  11  horizontal counter from the timing generator.
REQ-008 vc  in  11  vertical counter from the timing generator.
REQ-009 btn_next  in  1  raw asynchronous push-button; high means pressed.
REQ-010 btn_mode  in  1  raw asynchronous push-button; high means pressed.
REQ-011 pattern_sel  out  2  pattern index to the pattern generator.
REQ-012 auto_mode  out  1  1 = AUTO state, 0 = MANUAL state.
REQ-013 pattern_update  out  1  one-cycle pulse on the cycle after pattern_sel changes.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 A press SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; a held button gives exactly one press.
REQ-016 frame_tick SHALL be combinational (hc==0 && vc==V_ACTIVE), i.e. one cycle per frame.
REQ-017 State machine: MANUAL and AUTO; a mode press toggles the state on the next edge, independent of frame_tick.
REQ-018 Every state toggle SHALL clear the frame counter to 0; a pending advance survives the toggle.
REQ-019 A next press SHALL set the pending flag, in either state; further presses before the boundary do not accumulate.
REQ-020 At frame_tick, if pending is set: pattern_sel advances by 1, pending clears, and the frame counter clears.
REQ-021 At frame_tick in AUTO with no pending advance: when frame counter == AUTO_FRAMES-1, pattern_sel advances and the counter clears; otherwise the counter increments.
REQ-022 pending and auto-expiry on the same frame_tick SHALL advance exactly once.
REQ-023 A next press on the same cycle as frame_tick SHALL be taken at the following frame_tick, not the current one.
REQ-024 Advance wraps NUM_PATTERNS-1 -> 0.
REQ-025 pattern_sel SHALL change only on the edge where frame_tick is high, so changes land only in vertical blanking.
REQ-026 In MANUAL the frame counter holds.
REQ-027 The frame counter is 8 bits and never exceeds AUTO_FRAMES-1.

Reset
REQ-028 Assertion of clr_n low SHALL asynchronously clear everything: pattern_sel=0, auto_mode=0 (MANUAL), pattern_update=0, pending=0, frame counter=0, debounced levels=0, debounce counters=0, synchronizer flops=0.
REQ-029 Reset mid-debounce or with an advance pending SHALL discard it; no press is generated after release unless the button is still held for DEBOUNCE_CYCLES.
REQ-030 Deassertion is synchronized externally; the block requires no reset synchronizer.

Structure
REQ-031 A shared package vga_pkg SHALL hold the state encoding (MANUAL=0, AUTO=1), the V_ACTIVE default and PATTERN_W=2.
REQ-032 One sub-module, btn_debounce (synchronizer + debouncer + press pulse), SHALL be instantiated twice.
REQ-033 All state is registered in a single clock domain; the outputs are direct register outputs.

Verification (V_ACTIVE=4, DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, NUM_PATTERNS=4, short frame counters)
REQ-034 btn_next high for 3 cycles then low -> no press, and pattern_sel stays 0 across 3 frames.
REQ-035 btn_next held for 20 cycles in MANUAL -> exactly one advance at the next frame_tick: pattern_sel 0->1, with pattern_update high for 1 cycle.
REQ-036 Press btn_mode, then run 12 frames -> auto_mode=1 and pattern_sel sequence 1,2,3,0 at every 3rd frame_tick, with wrap verified.
REQ-037 In AUTO with frame counter==2, press next so pending is set before the same frame_tick -> a single advance, and the counter restarts at 0.
REQ-038 Next press on the frame_tick cycle -> no change at that tick; advance at the following tick.
REQ-039 Pull clr_n low with pending=1 and pattern_sel=2 -> all outputs 0 immediately (asynchronously), and no advance after release.
